hamming_decoder_serial: RTL and testbench

Hamming(7,4) receive-side block for the single-error-correcting link whose transmit side serially assembles data bits into a 7-bit codeword. Accepts one parallel 7-bit codeword per write strobe, computes the 3-bit syndrome and corrects any single-bit error. Presents the corrected nibble in parallel and also shifts it out serially, one bit per clock with a valid flag. Sits between the codeword capture register of the link and the downstream serial data consumer.

---
 rtl/hamming_decoder_serial_if.sv | 23 ++
 rtl/hamming_decoder_serial.sv | 97 +++++++++
 tb/tb_hamming_decoder_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hamming_decoder_serial_if.sv
// Codeword-in / corrected-data-out bundle for the Hamming(7,4) serial decoder.
interface hamming_decoder_serial_if;
    logic       write;
    logic [6:0] data_inp;
    logic       ready;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic       err_corrected;
    logic       data_outp;
    logic       valid;

    // Codeword source side
    modport master (
        output write, data_inp,
        input  ready, data_out, syndrome, err_corrected, data_outp, valid
    );

    // Decoder side
    modport slave (
        input  write, data_inp,
        output ready, data_out, syndrome, err_corrected, data_outp, valid
    );
endinterface

// File: rtl/hamming_decoder_serial.sv
// Hamming(7,4) receiver: captures a codeword, corrects a single-bit error,
// presents the nibble in parallel and shifts it out serially d1 first.
module hamming_decoder_serial (
    input  logic                      clk,
    input  logic                      reset,
    hamming_decoder_serial_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StDecode, StShift} state_e;

    state_e     state_q;
    logic [6:0] cw_q;
    logic [2:0] sh_q;
    logic [1:0] cnt_q;
    logic       ready_q;
    logic [3:0] data_out_q;
    logic [2:0] syndrome_q;
    logic       err_q;
    logic       data_outp_q;
    logic       valid_q;

    logic [2:0] syn_d;
    logic [6:0] flip_d;
    logic [6:0] fixed_d;
    logic [3:0] nib_d;

    // Syndrome of the captured word and the single-bit correction it implies
    always_comb begin
        syn_d[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6];
        syn_d[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6];
        syn_d[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];
        flip_d   = '0;
        if (syn_d != 3'd0) begin
            flip_d[syn_d - 3'd1] = 1'b1;
        end
        fixed_d = cw_q ^ flip_d;
        nib_d   = {fixed_d[6], fixed_d[5], fixed_d[4], fixed_d[2]};
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cw_q        <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            data_out_q  <= '0;
            syndrome_q  <= '0;
            err_q       <= 1'b0;
            data_outp_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.write) begin
                        cw_q    <= bus.data_inp;
                        ready_q <= 1'b0;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    data_out_q  <= nib_d;
                    syndrome_q  <= syn_d;
                    err_q       <= |syn_d;
                    // d1 goes out now; d2..d4 wait in the shifter
                    data_outp_q <= nib_d[0];
                    sh_q        <= nib_d[3:1];
                    valid_q     <= 1'b1;
                    cnt_q       <= 2'd0;
                    state_q     <= StShift;
                end
                StShift: begin
                    if (cnt_q == 2'd3) begin
                        valid_q     <= 1'b0;
                        data_outp_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        data_outp_q <= sh_q[0];
                        sh_q        <= {1'b0, sh_q[2:1]};
                        cnt_q       <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready         = ready_q;
    assign bus.data_out      = data_out_q;
    assign bus.syndrome      = syndrome_q;
    assign bus.err_corrected = err_q;
    assign bus.data_outp     = data_outp_q;
    assign bus.valid         = valid_q;

endmodule

// File: tb/tb_hamming_decoder_serial.sv
// Self-checking bench for hamming_decoder_serial.
module tb_hamming_decoder_serial;

    logic clk;
    logic reset;
    hamming_decoder_serial_if bus ();

    hamming_decoder_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built straight from the parity equations
    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic d1, d2, d3, d4;
        d1 = nib[0]; d2 = nib[1]; d3 = nib[2]; d4 = nib[3];
        return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
    endfunction

    // Decode by search: find the position whose flip yields a valid codeword
    function automatic logic [6:0] model_decode(input logic [6:0] cw);
        logic [6:0] t;
        logic [3:0] nib;
        for (int p = 0; p < 8; p++) begin
            t = cw;
            if (p != 0) t[p-1] = ~t[p-1];
            nib = {t[6], t[5], t[4], t[2]};
            if (encode(nib) == t) return {p[2:0], nib};
        end
        return 7'h0;
    endfunction

    // Timeline model: m_cnt = edges elapsed since capture, 0 when idle
    int         m_cnt;
    logic [6:0] m_cw;
    logic [3:0] m_nib;
    logic [2:0] m_syn;
    logic [6:0] m_dec;
    assign m_dec = model_decode(m_cw);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0;
            m_cw  <= '0;
            m_nib <= '0;
            m_syn <= '0;
        end else if (m_cnt == 0) begin
            if (bus.write) begin
                m_cw  <= bus.data_inp;
                m_cnt <= 1;
            end
        end else if (m_cnt == 1) begin
            m_nib <= m_dec[3:0];
            m_syn <= m_dec[6:4];
            m_cnt <= 2;
        end else if (m_cnt == 5) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_bit;
        exp_valid = (m_cnt >= 2) && (m_cnt <= 5);
        exp_bit   = exp_valid ? m_nib[m_cnt-2] : 1'b0;
        check("ready", {7'b0, bus.ready}, {7'b0, m_cnt == 0});
        check("valid", {7'b0, bus.valid}, {7'b0, exp_valid});
        check("data_outp", {7'b0, bus.data_outp}, {7'b0, exp_bit});
        check("data_out", {4'b0, bus.data_out}, {4'b0, m_nib});
        check("syndrome", {5'b0, bus.syndrome}, {5'b0, m_syn});
        check("err_corrected", {7'b0, bus.err_corrected}, {7'b0, m_syn != 3'd0});
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready: ready stayed 0 for %0d cycles", n);
        end
    endtask

    // Present a codeword for exactly one rising edge
    task automatic send(input logic [6:0] cw);
        @(negedge clk);
        bus.write    = 1'b1;
        bus.data_inp = cw;
        @(negedge clk);
        bus.write    = 1'b0;
    endtask

    // Capture one codeword and check it against hand-computed literals
    task automatic run_literal(input string name, input logic [6:0] cw, input logic [3:0] nib,
                               input logic [2:0] syn, input logic err, input logic [6:0] cw_ignored,
                               input logic inject);
        logic [3:0] ser;
        wait_ready();
        send(cw);
        check({name, "_ready_low"}, {7'b0, bus.ready}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({name, "_valid"}, {7'b0, bus.valid}, 8'd1);
            ser[i] = bus.data_outp;
            if (inject && i == 1) begin
                bus.write    = 1'b1;
                bus.data_inp = cw_ignored;
            end else begin
                bus.write = 1'b0;
            end
        end
        bus.write = 1'b0;
        check({name, "_data_out"}, {4'b0, bus.data_out}, {4'b0, nib});
        check({name, "_syndrome"}, {5'b0, bus.syndrome}, {5'b0, syn});
        check({name, "_err"}, {7'b0, bus.err_corrected}, {7'b0, err});
        check({name, "_serial"}, {4'b0, ser}, {4'b0, nib});
        @(negedge clk);
        check({name, "_ready_back"}, {7'b0, bus.ready}, 8'd1);
        check({name, "_valid_off"}, {7'b0, bus.valid}, 8'd0);
    endtask

    initial begin
        bus.write    = 1'b0;
        bus.data_inp = '0;
        reset        = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", {7'b0, bus.ready}, 8'd1);
        check("rst_valid", {7'b0, bus.valid}, 8'd0);
        check("rst_data_out", {4'b0, bus.data_out}, 8'd0);
        check("rst_syndrome", {5'b0, bus.syndrome}, 8'd0);
        check("rst_err", {7'b0, bus.err_corrected}, 8'd0);

        // Model anchors
        check("enc_1010", {1'b0, encode(4'b1010)}, 8'b0101_0010);
        check("dec_pos5", {1'b0, model_decode(7'b1000010)}, {1'b0, 3'b101, 4'b1010});

        run_literal("clean", 7'b1010010, 4'b1010, 3'b000, 1'b0, 7'h0, 1'b0);
        run_literal("data_err", 7'b1000010, 4'b1010, 3'b101, 1'b1, 7'h0, 1'b0);
        run_literal("parity_err", 7'b1001110, 4'b1001, 3'b010, 1'b1, 7'h0, 1'b0);
        // Write during SHIFT with a different codeword must be ignored
        run_literal("write_busy", 7'b1010010, 4'b1010, 3'b000, 1'b0, 7'b0110011, 1'b1);

        // Sweep every nibble with every single-bit error position
        for (int nib = 0; nib < 16; nib++) begin
            for (int e = 0; e < 8; e++) begin
                logic [6:0] cw;
                cw = encode(nib[3:0]);
                if (e != 0) cw[e-1] = ~cw[e-1];
                wait_ready();
                send(cw);
                repeat (5) @(negedge clk);
                check("sweep_nib", {4'b0, bus.data_out}, {4'b0, nib[3:0]});
                check("sweep_syn", {5'b0, bus.syndrome}, {5'b0, e[2:0]});
            end
        end

        // Reset mid-SHIFT aborts at once
        wait_ready();
        send(7'b1001110);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", {7'b0, bus.ready}, 8'd1);
        check("abort_valid", {7'b0, bus.valid}, 8'd0);
        check("abort_outp", {7'b0, bus.data_outp}, 8'd0);
        check("abort_data_out", {4'b0, bus.data_out}, 8'd0);
        check("abort_syndrome", {5'b0, bus.syndrome}, 8'd0);
        check("abort_err", {7'b0, bus.err_corrected}, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post_abort_valid", {7'b0, bus.valid}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
